estagio_writeback: RTL and testbench

MEM/WB pipeline stage of the MIPS datapath, sitting directly upstream of the register bank. It does four things:
- latches the memory-stage result;
- performs load byte/halfword extraction and sign/zero extension;
- selects ALU versus load data;
- drives the register bank's write port (modeWE/addrDataIn/dataIn).

It also counts retired instructions and, optionally, exposes a WB→EX forwarding path.

---
 rtl/estagio_writeback.sv | 128 ++++++++++++
 tb/tb_estagio_writeback.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/estagio_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : estagio_writeback                                               |
// | Purpose  : MIPS MEM/WB stage: load extract, result select, RF write port,  |
// |            retirement counter. Macro WB_FORWARD_EN adds a WB->EX forward.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module estagio_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_mem_to_reg,
  input  logic [2:0]        mem_load_type,
  input  logic [1:0]        mem_byte_off,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic [ADDR_W-1:0] mem_dest,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              wb_valid,
  output logic [31:0]       retired_count,
  input  logic [ADDR_W-1:0] fwd_addr1,
  input  logic [ADDR_W-1:0] fwd_addr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data
);

  localparam logic [2:0] c_LT_LB  = 3'b001;
  localparam logic [2:0] c_LT_LBU = 3'b010;
  localparam logic [2:0] c_LT_LH  = 3'b011;
  localparam logic [2:0] c_LT_LHU = 3'b100;

  logic              r_wb_valid;
  logic              r_wb_reg_write;
  logic [ADDR_W-1:0] r_wb_dest;
  logic [DATA_W-1:0] r_wb_data;
  logic [31:0]       r_retired_count;

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load_value;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_dest_live;
  logic              w_retire;

  // Big-endian lanes: byte 0 is the most significant byte of the word
  always_comb begin
    w_byte = mem_load_data[31:24];
    case (mem_byte_off)
      2'd0:    w_byte = mem_load_data[31:24];
      2'd1:    w_byte = mem_load_data[23:16];
      2'd2:    w_byte = mem_load_data[15:8];
      default: w_byte = mem_load_data[7:0];
    endcase
    w_half = mem_byte_off[1] ? mem_load_data[15:0] : mem_load_data[31:16];
  end

  always_comb begin
    w_load_value = mem_load_data;
    case (mem_load_type)
      c_LT_LB:  w_load_value = {{(DATA_W-8){w_byte[7]}}, w_byte};
      c_LT_LBU: w_load_value = {{(DATA_W-8){1'b0}}, w_byte};
      c_LT_LH:  w_load_value = {{(DATA_W-16){w_half[15]}}, w_half};
      c_LT_LHU: w_load_value = {{(DATA_W-16){1'b0}}, w_half};
      default:  w_load_value = mem_load_data;
    endcase
    w_sel_data = mem_mem_to_reg ? w_load_value : mem_alu_result;
  end

  // Flush wins over stall so a squashed instruction can never retire later
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_dest      <= '0;
      r_wb_data      <= '0;
    end else if (flush) begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_dest      <= '0;
      r_wb_data      <= '0;
    end else if (!stall) begin
      r_wb_valid     <= mem_valid;
      r_wb_reg_write <= mem_reg_write;
      r_wb_dest      <= mem_dest;
      r_wb_data      <= w_sel_data;
    end
  end

  assign w_retire = r_wb_valid & ~stall & ~flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_retired_count <= 32'd0;
    end else if (w_retire) begin
      r_retired_count <= r_retired_count + 32'd1;
    end
  end

  assign w_dest_live   = r_wb_valid & r_wb_reg_write & (r_wb_dest != '0);
  assign rf_we         = w_dest_live & ~stall & ~flush;
  assign rf_addr       = r_wb_dest;
  assign rf_data       = r_wb_data;
  assign wb_valid      = r_wb_valid;
  assign retired_count = r_retired_count;

`ifdef WB_FORWARD_EN
  assign fwd_hit1 = w_dest_live & (r_wb_dest == fwd_addr1);
  assign fwd_hit2 = w_dest_live & (r_wb_dest == fwd_addr2);
  assign fwd_data = r_wb_data;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd_addr1, fwd_addr2};
  assign fwd_hit1     = 1'b0;
  assign fwd_hit2     = 1'b0;
  assign fwd_data     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_estagio_writeback.sv
`default_nettype none
// Randomized bench for estagio_writeback against an abstract stage model.
module tb_estagio_writeback;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall, flush;
  logic        mem_valid, mem_reg_write, mem_mem_to_reg;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_byte_off;
  logic [31:0] mem_alu_result, mem_load_data;
  logic [4:0]  mem_dest;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        wb_valid;
  logic [31:0] retired_count;
  logic [4:0]  fwd_addr1, fwd_addr2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data;

  estagio_writeback #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_load_type(mem_load_type),
    .mem_byte_off(mem_byte_off), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_dest(mem_dest),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .wb_valid(wb_valid), .retired_count(retired_count),
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data(fwd_data)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model of what the stage currently holds
  bit          m_valid, m_rw;
  int unsigned m_dest, m_data, m_count;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_load(input int lt, input int off, input int unsigned w);
    int unsigned b, h;
    b = (w >> (8 * (3 - off))) & 32'hFF;
    h = (off >= 2) ? (w & 32'hFFFF) : (w >> 16);
    case (lt)
      1: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      2: return b;
      3: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      4: return h;
      default: return w;
    endcase
  endfunction

  task automatic drive(input bit v, input bit rw, input bit m2r, input int lt, input int off,
                       input int unsigned alu, input int unsigned ld, input int d,
                       input bit st, input bit fl, input int f1, input int f2);
    mem_valid = v; mem_reg_write = rw; mem_mem_to_reg = m2r;
    mem_load_type = 3'(lt); mem_byte_off = 2'(off);
    mem_alu_result = alu; mem_load_data = ld; mem_dest = 5'(d);
    stall = st; flush = fl; fwd_addr1 = 5'(f1); fwd_addr2 = 5'(f2);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fwd_addr1, fwd_addr2);
  endtask

  // Compare all outputs against the model, then advance one edge
  task automatic cycle();
    bit          live, n_valid, n_rw, retire;
    int unsigned n_dest, n_data;
    #3;
    live = m_valid && m_rw && (m_dest != 0);
    check_val("rf_we", rf_we, live && !stall && !flush);
    check_val("rf_addr", rf_addr, m_dest);
    check_val("rf_data", rf_data, m_data);
    check_val("wb_valid", wb_valid, m_valid);
    check_val("retired", retired_count, m_count);
`ifdef WB_FORWARD_EN
    check_val("hit1", fwd_hit1, live && (m_dest == fwd_addr1));
    check_val("hit2", fwd_hit2, live && (m_dest == fwd_addr2));
    check_val("fwd_data", fwd_data, m_data);
`else
    check_val("hit1", fwd_hit1, 0);
    check_val("hit2", fwd_hit2, 0);
    check_val("fwd_data", fwd_data, 0);
`endif
    retire = m_valid && !stall && !flush;
    if (flush) begin
      n_valid = 0; n_rw = 0; n_dest = 0; n_data = 0;
    end else if (stall) begin
      n_valid = m_valid; n_rw = m_rw; n_dest = m_dest; n_data = m_data;
    end else begin
      n_valid = mem_valid; n_rw = mem_reg_write; n_dest = mem_dest;
      n_data = mem_mem_to_reg ? ref_load(mem_load_type, mem_byte_off, mem_load_data)
                              : mem_alu_result;
    end
    @(posedge clock);
    m_valid = n_valid; m_rw = n_rw; m_dest = n_dest; m_data = n_data;
    if (retire) m_count = m_count + 1;
    #1;
  endtask

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_dest = 0; m_data = 0; m_count = 0;
  endtask

  typedef struct { int lt; int off; int unsigned exp; } load_case_t;
  load_case_t lc [5];

  initial begin
    lc[0] = '{1, 0, 32'hFFFFFF80};
    lc[1] = '{2, 1, 32'h000000FF};
    lc[2] = '{3, 2, 32'h00007F01};
    lc[3] = '{4, 0, 32'h000080FF};
    lc[4] = '{0, 3, 32'h80FF7F01};

    reset_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_we", rf_we, 0);
    check_val("rst_addr", rf_addr, 0);
    check_val("rst_data", rf_data, 0);
    check_val("rst_cnt", retired_count, 0);
    check_val("rst_fwd", fwd_data, 0);
    reset_n = 1;

    drive(1, 1, 0, 0, 0, 32'h12345678, 0, 5, 0, 0, 0, 0);
    cycle();
    idle(); #1;
    check_val("alu_we", rf_we, 1);
    check_val("alu_addr", rf_addr, 5);
    check_val("alu_data", rf_data, 32'h12345678);
    cycle();
    check_val("alu_cnt", retired_count, 1);

    foreach (lc[i]) begin
      drive(1, 1, 1, lc[i].lt, lc[i].off, 32'hDEADBEEF, 32'h80FF7F01, 3, 0, 0, 0, 0);
      cycle();
      idle(); #1;
      check_val($sformatf("load%0d", i), rf_data, lc[i].exp);
      cycle();
    end

    drive(1, 1, 0, 0, 0, 32'h55, 0, 0, 0, 0, 0, 0);
    cycle();
    idle(); #1;
    check_val("zero_we", rf_we, 0);
    cycle();
    check_val("zero_cnt", retired_count, 7);

    drive(1, 1, 0, 0, 0, 32'hA5A5A5A5, 0, 9, 0, 0, 0, 0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); #1;
      check_val("stall_we", rf_we, 0);
      check_val("stall_cnt", retired_count, 7);
      check_val("stall_data", rf_data, 32'hA5A5A5A5);
      cycle();
    end
    idle(); #1;
    check_val("unstall_we", rf_we, 1);
    cycle();
    check_val("unstall_cnt", retired_count, 8);
    #1;
    check_val("unstall_once", rf_we, 0);

    drive(1, 1, 0, 0, 0, 32'h0BADF00D, 0, 10, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0); #1;
    check_val("flush_we", rf_we, 0);
    cycle();
    idle(); #1;
    check_val("flush_valid", wb_valid, 0);
    check_val("flush_cnt", retired_count, 8);

    drive(1, 1, 0, 0, 0, 32'hCAFEF00D, 0, 7, 0, 0, 7, 3);
    cycle();
    idle(); #1;
`ifdef WB_FORWARD_EN
    check_val("fwd_h1", fwd_hit1, 1);
    check_val("fwd_h2", fwd_hit2, 0);
    check_val("fwd_d", fwd_data, 32'hCAFEF00D);
`else
    check_val("fwd_h1", fwd_hit1, 0);
    check_val("fwd_h2", fwd_hit2, 0);
`endif
    cycle();

    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      int d, f1, f2;
      r  = $urandom;
      d  = (r[3:0] == 0) ? 0 : int'($urandom_range(31, 0));
      f1 = r[4] ? d : int'($urandom_range(31, 0));
      f2 = r[5] ? d : int'($urandom_range(31, 0));
      drive(r[31:29] != 0, r[28:26] != 0, r[25], int'($urandom_range(7, 0)),
            int'($urandom_range(3, 0)), $urandom, $urandom, d,
            r[24:22] == 0, r[21:19] == 0, f1, f2);
      cycle();
    end

    drive(1, 1, 0, 0, 0, 32'h77, 0, 12, 0, 0, 12, 12);
    cycle();
    #2;
    reset_n = 0;
    #1;
    check_val("mid_rst_we", rf_we, 0);
    check_val("mid_rst_addr", rf_addr, 0);
    check_val("mid_rst_data", rf_data, 0);
    check_val("mid_rst_valid", wb_valid, 0);
    check_val("mid_rst_cnt", retired_count, 0);
    check_val("mid_rst_hit", fwd_hit1, 0);
    model_reset();
    @(posedge clock); #1;
    reset_n = 1;
    idle();
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
